// File: rtl/mem_copy_dma.sv
// mem_copy_dma: forward word-at-a-time block copy over the data RAM port.
// Optional MEM_COPY_PROTECT_EN aborts on writes into the 0x200-0x204 window.
module mem_copy_dma #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, FIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] wdata_q;
  logic              hit;

`ifdef MEM_COPY_PROTECT_EN
  localparam logic [ADDR_W-1:0] WIN_LO = ADDR_W'(32'h200);
  localparam logic [ADDR_W-1:0] WIN_HI = ADDR_W'(32'h204);

  assign hit = (dst >= WIN_LO) && (dst <= WIN_HI);
  assign err = (state == WR) && hit;
`else
  assign hit = 1'b0;
  assign err = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) state <= IDLE;
    else            state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (length == '0) ? FIN : RD;
      RD:   state_nx = CAP;
      CAP:  state_nx = WR;
      WR: begin
        if (hit)                   state_nx = IDLE;
        else if (len == LEN_W'(1)) state_nx = FIN;
        else                       state_nx = RD;
      end
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // address/length counters, read buffer and held bus values
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      if (state == IDLE && start) begin
        src <= src_addr;
        dst <= dst_addr;
        len <= length;
      end
      if (state == CAP) buf_q <= mem_rdata;
      if (state == WR && !hit) begin
        src <= src + ADDR_W'(1);
        dst <= dst + ADDR_W'(1);
        len <= len - LEN_W'(1);
      end
    end
  end

  // bus and status outputs decoded from registered state
  always_comb begin
    busy      = (state == RD) || (state == CAP) || (state == WR);
    done      = (state == FIN);
    mem_we    = (state == WR) && !hit;
    mem_wdata = (state == WR) ? buf_q : wdata_q;
    unique case (state)
      RD, CAP: mem_addr = src;
      WR:      mem_addr = dst;
      default: mem_addr = addr_q;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: random and directed copies checked against a
// sequential word-copy model of the RAM contents.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic        start;
  logic [10:0] src_addr;
  logic [10:0] dst_addr;
  logic [11:0] length;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] ram [0:2047];
  logic [15:0] exp_mem [0:2047];
  logic [10:0] addr_log [$];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_copy_dma dut (
    .clk(clk), .reset_bar(reset_bar), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // synchronous RAM: read data one cycle after address, read-before-write
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  function automatic bit in_win(input logic [10:0] a);
`ifdef MEM_COPY_PROTECT_EN
    return (a >= 11'h200) && (a <= 11'h204);
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 16'($urandom);
      exp_mem[i] = ram[i];
    end
  endtask

  // reference: forward copy one word at a time, stop at a protected word
  task automatic model_copy(input logic [10:0] s, input logic [10:0] d,
                            input int l, output int writes,
                            output bit abort);
    logic [10:0] ra;
    logic [10:0] wa;
    writes = 0;
    abort = 1'b0;
    for (int i = 0; i < l; i++) begin
      ra = s + 11'(i);
      wa = d + 11'(i);
      if (in_win(wa)) begin
        abort = 1'b1;
        break;
      end
      exp_mem[wa] = exp_mem[ra];
      writes++;
    end
  endtask

  task automatic check_mem(input string name);
    int diffs = 0;
    int first = -1;
    for (int i = 0; i < 2048; i++)
      if (ram[i] !== exp_mem[i]) begin
        diffs++;
        if (first < 0) first = i;
      end
    n_checks++;
    if (diffs != 0) begin
      n_fail++;
      $display("FAIL %s mem: %0d words differ, first @%0h got %0h want %0h",
               name, diffs, first, ram[first], exp_mem[first]);
    end
  endtask

  task automatic do_copy(input logic [10:0] s, input logic [10:0] d,
                         input logic [11:0] l, input bit poke,
                         output int done_at, output int err_at,
                         output int we_cnt, output int busy_bad);
    done_at = -1;
    err_at = -1;
    we_cnt = 0;
    busy_bad = 0;
    addr_log.delete();
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length = l;
    start = 1'b1;
    for (int k = 1; k <= 3 * int'(l) + 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 2) begin
        start = 1'b1;
        src_addr = s + 11'd5;
        dst_addr = d + 11'd9;
        length = 12'd7;
      end
      addr_log.push_back(mem_addr);
      if (mem_we) we_cnt++;
      if (done) begin
        if (busy) busy_bad++;
        done_at = k;
        break;
      end
      if (err) begin
        err_at = k;
        break;
      end
      if (!busy) busy_bad++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_bar = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    #2;
    n_checks++;
    if ({busy, done, err, mem_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, err, mem_we});
    end
    n_checks++;
    if (mem_addr !== 11'h0 || mem_wdata !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %0h data %0h want 0 0",
               mem_addr, mem_wdata);
    end
    @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, mem_we} !== 3'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, done, mem_we});
    end
  endtask

  task automatic test_basic();
    int da, ea, wc, bb, wr;
    bit ab;
    fill_mem();
    ram[0] = 16'hC0DE;
    ram[1] = 16'hBEEF;
    exp_mem[0] = 16'hC0DE;
    exp_mem[1] = 16'hBEEF;
    model_copy(11'h000, 11'h010, 2, wr, ab);
    do_copy(11'h000, 11'h010, 12'd2, 1'b0, da, ea, wc, bb);
    n_checks++;
    if (da !== 7) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d want 7", da);
    end
    n_checks++;
    if (wc !== 2 || bb !== 0) begin
      n_fail++;
      $display("FAIL basic_we_busy: got we %0d busybad %0d want 2 0", wc, bb);
    end
    n_checks++;
    if (ram[16] !== 16'hC0DE || ram[17] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL basic_data: got %0h %0h want c0de beef", ram[16], ram[17]);
    end
    n_checks++;
    if (addr_log[addr_log.size()-1] !== 11'h011) begin
      n_fail++;
      $display("FAIL fin_addr_hold: got %0h want 11",
               addr_log[addr_log.size()-1]);
    end
    @(negedge clk);
    n_checks++;
    if (mem_addr !== 11'h011 || mem_wdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL idle_hold: got %0h %0h want 11 beef", mem_addr, mem_wdata);
    end
    check_mem("basic");
  endtask

  task automatic test_zero_len();
    int da, ea, wc, bb;
    bit seen;
    fill_mem();
    do_copy(11'h123, 11'h456, 12'd0, 1'b0, da, ea, wc, bb);
    n_checks++;
    if (da !== 1 || wc !== 0 || bb !== 0) begin
      n_fail++;
      $display("FAIL zero_len: got done %0d we %0d busybad %0d want 1 0 0",
               da, wc, bb);
    end
    start = 1'b1;
    length = 12'd3;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done || mem_we) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_fin: got activity %b want 0", seen);
    end
    check_mem("zero_len");
  endtask

  task automatic test_wrap();
    int da, ea, wc, bb, wr;
    bit ab;
    fill_mem();
    ram[2047] = 16'h1234;
    ram[0] = 16'h5678;
    exp_mem[2047] = 16'h1234;
    exp_mem[0] = 16'h5678;
    model_copy(11'h7FF, 11'h100, 2, wr, ab);
    do_copy(11'h7FF, 11'h100, 12'd2, 1'b0, da, ea, wc, bb);
    n_checks++;
    if (addr_log.size() < 4 || addr_log[0] !== 11'h7FF
        || addr_log[3] !== 11'h000) begin
      n_fail++;
      $display("FAIL wrap_reads: got %0h %0h want 7ff 0",
               addr_log[0], addr_log[3]);
    end
    n_checks++;
    if (ram[256] !== 16'h1234 || ram[257] !== 16'h5678 || da !== 7) begin
      n_fail++;
      $display("FAIL wrap_data: got %0h %0h done %0d want 1234 5678 7",
               ram[256], ram[257], da);
    end
    check_mem("wrap");
  endtask

  task automatic test_ignore_start();
    int da, ea, wc, bb, wr;
    bit ab;
    fill_mem();
    model_copy(11'h020, 11'h300, 3, wr, ab);
    do_copy(11'h020, 11'h300, 12'd3, 1'b1, da, ea, wc, bb);
    n_checks++;
    if (da !== 10 || wc !== 3) begin
      n_fail++;
      $display("FAIL ignore_start: got done %0d we %0d want 10 3", da, wc);
    end
    check_mem("ignore_start");
  endtask

  task automatic test_async_reset();
    bit hit = 1'b0;
    fill_mem();
    @(negedge clk);
    src_addr = 11'h040;
    dst_addr = 11'h080;
    length = 12'd4;
    start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_we) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL areset_reach_wr: got no write within 20 cycles want write");
    end
    reset_bar = 1'b0;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 11'h0) begin
      n_fail++;
      $display("FAIL areset_drop: got we %b busy %b addr %0h want 0 0 0",
               mem_we, busy, mem_addr);
    end
    @(negedge clk);
    reset_bar = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || done || mem_we) hit = 1'b1;
    end
    n_checks++;
    if (hit !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_idle: got activity %b want 0", hit);
    end
  endtask

  task automatic test_protect_window();
    int da, ea, wc, bb, wr;
    bit ab;
    fill_mem();
    model_copy(11'h050, 11'h1FF, 3, wr, ab);
    do_copy(11'h050, 11'h1FF, 12'd3, 1'b0, da, ea, wc, bb);
    n_checks++;
    if (wc !== wr) begin
      n_fail++;
      $display("FAIL protect_writes: got %0d want %0d", wc, wr);
    end
    n_checks++;
    if (ab ? (ea !== 3 * wr + 3 || da !== -1) : (ea !== -1 || da !== 10)) begin
      n_fail++;
      $display("FAIL protect_status: got done %0d err %0d (abort %b)",
               da, ea, ab);
    end
    check_mem("protect");
  endtask

  task automatic test_random();
    int da, ea, wc, bb, wr, l;
    bit ab;
    logic [10:0] s, d;
    for (int it = 0; it < 8; it++) begin
      fill_mem();
      s = 11'($urandom);
      d = (it % 3 == 0) ? s + 11'($urandom_range(1, 4)) : 11'($urandom);
      l = $urandom_range(1, 40);
      model_copy(s, d, l, wr, ab);
      do_copy(s, d, 12'(l), 1'b0, da, ea, wc, bb);
      n_checks++;
      if (wc !== wr || bb !== 0
          || (!ab && da !== 3 * l + 1) || (ab && ea !== 3 * wr + 3)) begin
        n_fail++;
        $display("FAIL random_%0d: got we %0d done %0d err %0d busybad %0d want we %0d len %0d",
                 it, wc, da, ea, bb, wr, l);
      end
      check_mem("random");
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_ignore_start();
    test_async_reset();
    test_protect_window();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
